// File: rtl/rs_scheduler_pkg.sv
// Shared constants for the reservation-station scheduler and its helpers.
package rs_scheduler_pkg;

    localparam int RSSZ    = 16;
    localparam int RSIDBW  = 4;
    localparam int ROBIDBW = 5;

    localparam logic TRUE  = 1'b1;
    localparam logic FALSE = 1'b0;

endpackage

// File: rtl/rs_scheduler_age_matrix.sv
// Program-order age tracking for RS entries and oldest-ready selection.
// older[i][j] = 1 means entry i was allocated before entry j.
module rs_age_matrix
    import rs_scheduler_pkg::*;
#(
    parameter int RSSZ   = rs_scheduler_pkg::RSSZ,
    parameter int RSIDBW = rs_scheduler_pkg::RSIDBW
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic              flush,
    input  logic              alloc_en,
    input  logic [RSIDBW-1:0] alloc_idx,
    input  logic              free_en,
    input  logic [RSIDBW-1:0] free_idx,
    input  logic [RSSZ-1:0]   occ,
    input  logic [RSSZ-1:0]   cand,
    output logic              pick_valid,
    output logic [RSIDBW-1:0] pick_idx
);

    logic [RSSZ-1:0] older     [RSSZ];
    logic [RSSZ-1:0] older_nxt [RSSZ];
    logic [RSSZ-1:0] blocked;
    logic [RSSZ-1:0] pick_onehot;

    // Next matrix: wipe the freed row/column, then stamp the new entry as youngest.
    // An entry freed on the same edge is not counted as older than the new one.
    always_comb begin
        older_nxt = older;
        if (free_en) begin
            for (int i = 0; i < RSSZ; i++) begin
                for (int j = 0; j < RSSZ; j++) begin
                    if (RSIDBW'(i) == free_idx || RSIDBW'(j) == free_idx) begin
                        older_nxt[i][j] = FALSE;
                    end
                end
            end
        end
        if (alloc_en) begin
            for (int j = 0; j < RSSZ; j++) begin
                older_nxt[alloc_idx][j] = FALSE;
                older_nxt[j][alloc_idx] = occ[j] && !(free_en && RSIDBW'(j) == free_idx);
            end
        end
    end

    // Matrix register; flush empties the whole station so all ordering is dropped.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < RSSZ; i++) older[i] <= '0;
        end else if (en) begin
            if (flush) begin
                for (int i = 0; i < RSSZ; i++) older[i] <= '0;
            end else begin
                older <= older_nxt;
            end
        end
    end

    // Oldest candidate: the one no other candidate precedes; reduce one-hot to index.
    always_comb begin
        blocked     = '0;
        pick_onehot = '0;
        pick_idx    = '0;
        for (int i = 0; i < RSSZ; i++) begin
            for (int j = 0; j < RSSZ; j++) begin
                if (cand[j] && older[j][i]) blocked[i] = TRUE;
            end
            pick_onehot[i] = cand[i] && !blocked[i];
        end
        for (int i = 0; i < RSSZ; i++) begin
            if (pick_onehot[i]) pick_idx = pick_idx | RSIDBW'(i);
        end
        pick_valid = |cand;
    end

endmodule

// File: rtl/rs_scheduler.sv
// Reservation-station allocate/wake/issue controller with a registered
// valid/ready issue port toward the ALU.
module rs_scheduler
    import rs_scheduler_pkg::*;
#(
    parameter int RSSZ   = rs_scheduler_pkg::RSSZ,
    parameter int RSIDBW = rs_scheduler_pkg::RSIDBW
) (
    input  logic              clk_in,
    input  logic              rst_in,
    input  logic              rdy_in,
    input  logic              alloc_req_in,
    input  logic              alloc_ready_in,
    output logic              alloc_grant_out,
    output logic [RSIDBW-1:0] alloc_idx_out,
    output logic              full_out,
    output logic [RSIDBW:0]   count_out,
    input  logic [RSSZ-1:0]   wake_mask_in,
    input  logic              flush_in,
    output logic              issue_valid_out,
    output logic [RSIDBW-1:0] issue_idx_out,
    input  logic              issue_ready_in
);

    localparam int CW = RSIDBW + 1;

    logic [RSSZ-1:0]   occ, rdy, issuing;
    logic [RSSZ-1:0]   cand, alloc_mask, free_mask, pick_mask;
    logic              handshake, issue_load, pick_valid;
    logic [RSIDBW-1:0] pick_idx;

    // Lowest-index free slot; stays 0 when the station is full.
    always_comb begin
        alloc_idx_out = '0;
        for (int i = RSSZ - 1; i >= 0; i--) begin
            if (!occ[i]) alloc_idx_out = RSIDBW'(i);
        end
    end

    // Handshake, grant and per-slot event masks.
    always_comb begin
        full_out        = (count_out == CW'(RSSZ));
        alloc_grant_out = alloc_req_in && !full_out && rdy_in;
        handshake       = issue_valid_out && issue_ready_in;
        cand            = occ & rdy & ~issuing;
        issue_load      = (!issue_valid_out || issue_ready_in) && pick_valid;
        alloc_mask      = alloc_grant_out ? (RSSZ'(1) << alloc_idx_out) : '0;
        free_mask       = handshake ? (RSSZ'(1) << issue_idx_out) : '0;
        pick_mask       = issue_load ? (RSSZ'(1) << pick_idx) : '0;
    end

    rs_age_matrix #(
        .RSSZ   (RSSZ),
        .RSIDBW (RSIDBW)
    ) u_age (
        .clk        (clk_in),
        .rst_n      (rst_in),
        .en         (rdy_in),
        .flush      (flush_in),
        .alloc_en   (alloc_grant_out),
        .alloc_idx  (alloc_idx_out),
        .free_en    (handshake),
        .free_idx   (issue_idx_out),
        .occ        (occ),
        .cand       (cand),
        .pick_valid (pick_valid),
        .pick_idx   (pick_idx)
    );

    // Entry state, occupancy count and issue register; flush outranks everything.
    // Wake is masked by current occupancy, so a slot being allocated ignores it.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            occ             <= '0;
            rdy             <= '0;
            issuing         <= '0;
            count_out       <= '0;
            issue_valid_out <= FALSE;
            issue_idx_out   <= '0;
        end else if (rdy_in) begin
            if (flush_in) begin
                occ             <= '0;
                rdy             <= '0;
                issuing         <= '0;
                count_out       <= '0;
                issue_valid_out <= FALSE;
            end else begin
                occ       <= (occ & ~free_mask) | alloc_mask;
                rdy       <= ((rdy | (wake_mask_in & occ)) & ~free_mask & ~alloc_mask)
                             | (alloc_ready_in ? alloc_mask : '0);
                issuing   <= (issuing & ~free_mask) | pick_mask;
                count_out <= count_out + CW'(alloc_grant_out) - CW'(handshake);
                if (issue_load) begin
                    issue_valid_out <= TRUE;
                    issue_idx_out   <= pick_idx;
                end else if (handshake) begin
                    issue_valid_out <= FALSE;
                end
            end
        end
    end

endmodule

// File: tb/tb_rs_scheduler.sv
module tb_rs_scheduler;

    localparam int N = 16;

    logic        clk_in = 1'b0;
    logic        rst_in = 1'b0;
    logic        rdy_in = 1'b1;
    logic        alloc_req_in = 1'b0;
    logic        alloc_ready_in = 1'b0;
    logic        alloc_grant_out;
    logic [3:0]  alloc_idx_out;
    logic        full_out;
    logic [4:0]  count_out;
    logic [15:0] wake_mask_in = '0;
    logic        flush_in = 1'b0;
    logic        issue_valid_out;
    logic [3:0]  issue_idx_out;
    logic        issue_ready_in = 1'b0;

    int n_vec = 0;
    int n_err = 0;

    // reference model: sets of occupied/ready/issuing slots plus allocation sequence numbers
    bit [15:0] m_occ, m_rdy, m_iss;
    int        m_seq [N];
    int        seq_ctr;
    bit        m_v;
    int        m_idx;
    int        issued [$];

    rs_scheduler dut (
        .clk_in          (clk_in),
        .rst_in          (rst_in),
        .rdy_in          (rdy_in),
        .alloc_req_in    (alloc_req_in),
        .alloc_ready_in  (alloc_ready_in),
        .alloc_grant_out (alloc_grant_out),
        .alloc_idx_out   (alloc_idx_out),
        .full_out        (full_out),
        .count_out       (count_out),
        .wake_mask_in    (wake_mask_in),
        .flush_in        (flush_in),
        .issue_valid_out (issue_valid_out),
        .issue_idx_out   (issue_idx_out),
        .issue_ready_in  (issue_ready_in)
    );

    always #5 clk_in = ~clk_in;

    function automatic int f_count();
        int c = 0;
        for (int i = 0; i < N; i++) c += int'(m_occ[i]);
        return c;
    endfunction

    function automatic int f_free();
        for (int i = 0; i < N; i++) if (!m_occ[i]) return i;
        return 0;
    endfunction

    function automatic int f_pick();
        int best = -1;
        for (int i = 0; i < N; i++)
            if (m_occ[i] && m_rdy[i] && !m_iss[i] && (best < 0 || m_seq[i] < m_seq[best])) best = i;
        return best;
    endfunction

    task automatic m_reset();
        m_occ = '0; m_rdy = '0; m_iss = '0; m_v = 1'b0; m_idx = 0; seq_ctr = 0;
        for (int i = 0; i < N; i++) m_seq[i] = 0;
    endtask

    // advance one clock: compute model next state from current inputs, then commit after the edge
    task automatic tick();
        bit [15:0] n_occ, n_rdy, n_iss;
        bit        n_v, hs, g;
        int        n_idx, k, p;
        n_occ = m_occ; n_rdy = m_rdy; n_iss = m_iss; n_v = m_v; n_idx = m_idx;
        if (issue_valid_out && issue_ready_in && rdy_in && !flush_in) issued.push_back(int'(issue_idx_out));
        if (rdy_in) begin
            if (flush_in) begin
                n_occ = '0; n_rdy = '0; n_iss = '0; n_v = 1'b0;
            end else begin
                hs = m_v && issue_ready_in;
                g  = alloc_req_in && (f_count() < N);
                k  = f_free();
                p  = f_pick();
                for (int i = 0; i < N; i++) if (m_occ[i] && wake_mask_in[i]) n_rdy[i] = 1'b1;
                if (hs) begin
                    n_occ[m_idx] = 1'b0; n_rdy[m_idx] = 1'b0; n_iss[m_idx] = 1'b0;
                end
                if (g) begin
                    n_occ[k] = 1'b1; n_rdy[k] = alloc_ready_in; n_iss[k] = 1'b0;
                    m_seq[k] = seq_ctr; seq_ctr++;
                end
                if ((!m_v || issue_ready_in) && p >= 0) begin
                    n_v = 1'b1; n_idx = p; n_iss[p] = 1'b1;
                end else if (hs) begin
                    n_v = 1'b0;
                end
            end
        end
        @(posedge clk_in);
        #1;
        m_occ = n_occ; m_rdy = n_rdy; m_iss = n_iss; m_v = n_v; m_idx = n_idx;
    endtask

    task automatic idle_inputs();
        rdy_in = 1'b1; alloc_req_in = 1'b0; alloc_ready_in = 1'b0;
        wake_mask_in = '0; flush_in = 1'b0; issue_ready_in = 1'b0;
    endtask

    task automatic do_flush();
        idle_inputs();
        flush_in = 1'b1;
        tick();
        flush_in = 1'b0;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst_in = 1'b0;
        m_reset();
        @(posedge clk_in); #1;
        rst_in = 1'b1;
        alloc_req_in = 1'b1; alloc_ready_in = 1'b1;
        tick(); tick();
        alloc_req_in = 1'b0;
        #1;
        n_vec++;
        if (count_out !== 5'd2) begin n_err++; $display("FAIL pre_reset_count: got %0d expected 2", count_out); end
        #2;
        rst_in = 1'b0;
        #1;
        n_vec++;
        if (issue_valid_out !== 1'b0) begin n_err++; $display("FAIL reset_valid: got %0b expected 0", issue_valid_out); end
        n_vec++;
        if (count_out !== 5'd0) begin n_err++; $display("FAIL reset_count: got %0d expected 0", count_out); end
        n_vec++;
        if (full_out !== 1'b0) begin n_err++; $display("FAIL reset_full: got %0b expected 0", full_out); end
        n_vec++;
        if (alloc_idx_out !== 4'd0) begin n_err++; $display("FAIL reset_alloc_idx: got %0d expected 0", alloc_idx_out); end
        m_reset();
        @(posedge clk_in); #1;
        rst_in = 1'b1;
    endtask

    task automatic test_in_order();
        int exp_v [5]   = '{0, 1, 1, 1, 0};
        int exp_idx [5] = '{0, 0, 1, 2, 0};
        int exp_cnt [5] = '{1, 2, 2, 1, 0};
        idle_inputs();
        issue_ready_in = 1'b1; alloc_ready_in = 1'b1;
        for (int c = 0; c < 5; c++) begin
            alloc_req_in = (c < 3);
            tick();
            n_vec++;
            if (issue_valid_out !== 1'(exp_v[c])) begin
                n_err++; $display("FAIL inorder_valid c%0d: got %0b expected %0d", c, issue_valid_out, exp_v[c]);
            end
            if (exp_v[c] == 1) begin
                n_vec++;
                if (issue_idx_out !== 4'(exp_idx[c])) begin
                    n_err++; $display("FAIL inorder_idx c%0d: got %0d expected %0d", c, issue_idx_out, exp_idx[c]);
                end
            end
            n_vec++;
            if (count_out !== 5'(exp_cnt[c])) begin
                n_err++; $display("FAIL inorder_count c%0d: got %0d expected %0d", c, count_out, exp_cnt[c]);
            end
        end
        idle_inputs();
    endtask

    task automatic test_age_order();
        int exp_q [$] = '{0, 1, 2, 0};
        int guard = 0;
        idle_inputs();
        issued.delete();
        issue_ready_in = 1'b1;
        alloc_req_in = 1'b1;
        tick(); tick(); tick();
        alloc_req_in = 1'b0;
        wake_mask_in = 16'h0001;
        tick();
        wake_mask_in = '0;
        tick(); tick();
        #1;
        n_vec++;
        if (alloc_idx_out !== 4'd0) begin n_err++; $display("FAIL age_realloc_idx: got %0d expected 0", alloc_idx_out); end
        alloc_req_in = 1'b1;
        tick();
        alloc_req_in = 1'b0;
        wake_mask_in = 16'h0007;
        tick();
        wake_mask_in = '0;
        while ((count_out !== 5'd0 || issue_valid_out) && guard < 20) begin tick(); guard++; end
        n_vec++;
        if (issued != exp_q) begin
            n_err++; $display("FAIL age_order: got %p expected %p", issued, exp_q);
        end
    endtask

    task automatic test_full();
        idle_inputs();
        alloc_req_in = 1'b1;
        for (int i = 0; i < N; i++) tick();
        #1;
        n_vec++;
        if (full_out !== 1'b1) begin n_err++; $display("FAIL full_flag: got %0b expected 1", full_out); end
        n_vec++;
        if (count_out !== 5'd16) begin n_err++; $display("FAIL full_count: got %0d expected 16", count_out); end
        n_vec++;
        if (alloc_grant_out !== 1'b0) begin n_err++; $display("FAIL full_grant: got %0b expected 0", alloc_grant_out); end
        alloc_req_in = 1'b0;
        wake_mask_in = 16'h0020;
        tick();
        wake_mask_in = '0;
        tick();
        alloc_req_in = 1'b1; issue_ready_in = 1'b1;
        #1;
        n_vec++;
        if (alloc_grant_out !== 1'b0) begin n_err++; $display("FAIL full_hs_grant: got %0b expected 0", alloc_grant_out); end
        tick();
        alloc_req_in = 1'b0; issue_ready_in = 1'b0;
        #1;
        n_vec++;
        if (count_out !== 5'd15) begin n_err++; $display("FAIL freed_count: got %0d expected 15", count_out); end
        n_vec++;
        if (full_out !== 1'b0) begin n_err++; $display("FAIL freed_full: got %0b expected 0", full_out); end
        n_vec++;
        if (alloc_idx_out !== 4'd5) begin n_err++; $display("FAIL freed_alloc_idx: got %0d expected 5", alloc_idx_out); end
        do_flush();
    endtask

    task automatic test_hold();
        idle_inputs();
        alloc_req_in = 1'b1;
        for (int i = 0; i < 5; i++) tick();
        alloc_req_in = 1'b0;
        wake_mask_in = 16'h0008;
        tick();
        wake_mask_in = '0;
        tick();
        wake_mask_in = 16'h0010;
        tick();
        wake_mask_in = '0;
        for (int c = 0; c < 5; c++) begin
            tick();
            n_vec++;
            if ({issue_valid_out, issue_idx_out} !== 5'b1_0011) begin
                n_err++; $display("FAIL hold_idx c%0d: got v=%0b idx=%0d expected v=1 idx=3", c, issue_valid_out, issue_idx_out);
            end
        end
        issue_ready_in = 1'b1;
        tick();
        issue_ready_in = 1'b0;
        #1;
        n_vec++;
        if ({issue_valid_out, issue_idx_out} !== 5'b1_0100) begin
            n_err++; $display("FAIL hold_next_idx: got v=%0b idx=%0d expected v=1 idx=4", issue_valid_out, issue_idx_out);
        end
        n_vec++;
        if (alloc_idx_out !== 4'd3) begin n_err++; $display("FAIL hold_freed_idx: got %0d expected 3", alloc_idx_out); end
        n_vec++;
        if (count_out !== 5'd4) begin n_err++; $display("FAIL hold_count: got %0d expected 4", count_out); end
        do_flush();
    endtask

    task automatic test_flush();
        idle_inputs();
        alloc_req_in = 1'b1; alloc_ready_in = 1'b1;
        for (int i = 0; i < 6; i++) tick();
        alloc_req_in = 1'b0;
        #1;
        n_vec++;
        if ({issue_valid_out, count_out} !== 6'b1_00110) begin
            n_err++; $display("FAIL preflush: got v=%0b cnt=%0d expected v=1 cnt=6", issue_valid_out, count_out);
        end
        flush_in = 1'b1; issue_ready_in = 1'b1;
        tick();
        flush_in = 1'b0; issue_ready_in = 1'b0;
        #1;
        n_vec++;
        if ({issue_valid_out, count_out} !== 6'b0_00000) begin
            n_err++; $display("FAIL flush_state: got v=%0b cnt=%0d expected v=0 cnt=0", issue_valid_out, count_out);
        end
        alloc_req_in = 1'b1; alloc_ready_in = 1'b0;
        tick(); tick();
        rdy_in = 1'b0; flush_in = 1'b1;
        #1;
        n_vec++;
        if (alloc_grant_out !== 1'b0) begin n_err++; $display("FAIL stall_grant: got %0b expected 0", alloc_grant_out); end
        tick();
        idle_inputs();
        #1;
        n_vec++;
        if (count_out !== 5'd2) begin n_err++; $display("FAIL stall_flush_count: got %0d expected 2", count_out); end
        do_flush();
    endtask

    task automatic test_random();
        int ec;
        idle_inputs();
        for (int c = 0; c < 600; c++) begin
            rdy_in         = ($urandom_range(0, 9) != 0);
            alloc_req_in   = ($urandom_range(0, 9) < 6);
            alloc_ready_in = 1'($urandom_range(0, 1));
            wake_mask_in   = 16'($urandom & $urandom & $urandom);
            flush_in       = ($urandom_range(0, 59) == 0);
            issue_ready_in = ($urandom_range(0, 9) < 6);
            #1;
            ec = f_count();
            n_vec++;
            if (alloc_grant_out !== (alloc_req_in && ec < N && rdy_in)) begin
                n_err++; $display("FAIL rnd_grant c%0d: got %0b expected %0b", c, alloc_grant_out, alloc_req_in && ec < N && rdy_in);
            end
            n_vec++;
            if (alloc_idx_out !== 4'(f_free())) begin
                n_err++; $display("FAIL rnd_alloc_idx c%0d: got %0d expected %0d", c, alloc_idx_out, f_free());
            end
            n_vec++;
            if (count_out !== 5'(ec) || full_out !== (ec == N)) begin
                n_err++; $display("FAIL rnd_count c%0d: got cnt=%0d full=%0b expected cnt=%0d", c, count_out, full_out, ec);
            end
            n_vec++;
            if (issue_valid_out !== m_v) begin
                n_err++; $display("FAIL rnd_valid c%0d: got %0b expected %0b", c, issue_valid_out, m_v);
            end
            if (m_v) begin
                n_vec++;
                if (issue_idx_out !== 4'(m_idx)) begin
                    n_err++; $display("FAIL rnd_issue_idx c%0d: got %0d expected %0d", c, issue_idx_out, m_idx);
                end
            end
            tick();
        end
        idle_inputs();
    endtask

    initial begin
        m_reset();
        test_reset();
        test_in_order();
        test_age_order();
        test_full();
        test_hold();
        test_flush();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/rs_scheduler.md
Name: rs_scheduler

Overview:
Allocation and issue controller for the reservation station entry array. It tracks occupancy, operand-ready state and program-order age of every RS slot. It hands the decoder a free slot index and picks the oldest ready entry for the ALU over a registered valid/ready handshake. It sits between the ID stage, the RS storage array and the ALU, and is cleared by the ROB flush on branch mispredict.

Parameters:
RSSZ, 16, number of RS entries (power of two, at least 2)
RSIDBW, 4, log2(RSSZ), index width

Ports:
clk_in  input  1  clock, rising edge
rst_in  input  1  asynchronous, active-low reset
rdy_in  input  1  global enable; low holds all state
alloc_req_in  input  1  decoder requests a slot (inst_ID_flag and type routed to RS)
alloc_ready_in  input  1  both operands already available at allocation (Q1 and Q2 empty)
alloc_grant_out  output  1  combinational: alloc_req_in && !full_out && rdy_in
alloc_idx_out  output  RSIDBW  combinational: lowest-index free slot (0 when full)
full_out  output  1  combinational from registered state: count_out == RSSZ
count_out  output  RSIDBW+1  occupied entries
wake_mask_in  input  RSSZ  per-entry operands-became-ready strobes from CDB match
flush_in  input  1  clear all entries
issue_valid_out  output  1  registered: issue_idx_out holds a selected entry
issue_idx_out  output  RSIDBW  registered index for RS read and ALU dispatch
issue_ready_in  input  1  ALU accepts this cycle

Behaviour:
- Reset (rst_in=0, asynchronous): all occupied, ready, issuing and age bits cleared. issue_valid_out=0, issue_idx_out=0, count_out=0, full_out=0.
- rdy_in=0: no state changes, including flush. alloc_grant_out=0.
- Per-entry state: occ, rdy, issuing. Age matrix older[i][j]=1 means entry i was allocated before entry j.
- Allocation:
  - On a grant at edge N, slot k=alloc_idx_out becomes occ=1 and rdy=alloc_ready_in.
  - Age update: older[k][*]=0, and older[j][k]=1 for every j occupied before edge N.
  - The new entry is eligible for selection in cycle N+1.
- Wake:
  - wake_mask_in[i] sets rdy[i] only when occ[i]=1. Bits for unoccupied slots are ignored.
  - A wake at edge N makes the entry eligible in cycle N+1.
  - Wake and allocation of the same slot cannot coincide: the allocated slot is free and ignores wake.
- Selection:
  - Candidates are entries with occ && rdy && !issuing.
  - pick = the candidate i for which no other candidate j has older[j][i]=1.
- Issue register:
  - It loads at the edge when (!issue_valid_out || issue_ready_in) and a candidate exists.
  - On load: issue_idx_out=pick, issue_valid_out=1, issuing[pick]=1.
  - If no candidate exists and the handshake completes, issue_valid_out drops to 0.
  - While issue_valid_out && !issue_ready_in, issue_idx_out is held stable.
- Free:
  - A handshake (issue_valid_out && issue_ready_in) at edge N clears occ, rdy and issuing for issue_idx_out.
  - The freed slot is allocatable from cycle N+1.
  - Back-to-back issue is allowed: the next pick loads on the same edge.
- Latency: allocation with alloc_ready_in=1 at edge N gives issue_valid_out at cycle N+2 at the earliest.
- Simultaneous events:
  - Alloc and free in the same cycle: count_out unchanged.
  - Alloc and free are at different slots by construction.
  - A full RS with a completing handshake still gives alloc_grant_out=0 that cycle, because full_out is computed from registered state.
- Flush (with rdy_in=1): has priority over alloc, wake and issue. Next cycle all entries are empty, issue_valid_out=0 and count_out=0. A handshake in the flush cycle is still seen by the ALU; the scheduler ignores it.
- Width: count_out is RSIDBW+1 bits so it can reach RSSZ without wrap.

Decomposition:
- Shared defines header holds RSSZ, RSIDBW, ROBIDBW and True/False, alongside the existing RS constants.
- One sub-module: rs_age_matrix. It does the allocate-time row/column update, the clear on free and flush, and the combinational oldest-candidate select (one-hot to index).
- The free-slot priority encoder stays inline.

Test Plan:
1. Reset with rst_in low mid-cycle -> immediately issue_valid_out=0, count_out=0, full_out=0, alloc_idx_out=0.
2. Allocate three ready instructions on consecutive cycles 1-3 with issue_ready_in=1 -> issue_idx_out 0, 1, 2 valid in cycles 3, 4, 5; count_out returns to 0.
3. Allocate idx0-2 not ready. Wake idx0 and issue it. Allocate again (gets idx0, now youngest). Wake all -> issue order 1, 2, 0.
4. Allocate 16 not-ready -> full_out=1, count_out=16, and a 17th request gets alloc_grant_out=0. Wake idx5 and complete the handshake -> count_out=15, full_out=0, alloc_idx_out=5.
5. Hold issue_ready_in=0 for 5 cycles with idx3 selected and idx4 ready -> issue_idx_out stays 3. Raise issue_ready_in -> idx4 appears next cycle and idx3 is freed.
6. Flush while issue_valid_out=1 and count_out=6 -> next cycle issue_valid_out=0, count_out=0. Separately, flush with rdy_in=0 -> state unchanged.
